// File: rtl/mdu_pkg.sv
// Shared types and constants for the E-stage multiply/divide unit.
// The MDU_DIV_EN macro decides whether DIV/DIVU count as multi-cycle ops.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } mdu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Ops that load the counter and raise busy; divides only when the divider exists.
  function automatic logic op_is_multi(input mdu_op_t op);
`ifdef MDU_DIV_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational {hi,lo} result for MULT/MULTU/DIV/DIVU.
// Divide hardware only exists when MDU_DIV_EN is defined.
import mdu_pkg::*;

module mdu_calc (
  input  mdu_op_t     op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        write_en
);

  logic        is_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;

  assign is_signed = (op == OP_MULT) || (op == OP_DIV);

  // Sign- or zero-extending to 64 bits lets one unsigned multiplier serve both forms.
  assign a_ext   = {{32{is_signed & rs[31]}}, rs};
  assign b_ext   = {{32{is_signed & rt[31]}}, rt};
  assign product = a_ext * b_ext;

`ifdef MDU_DIV_EN
  logic        is_div;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
  assign neg_a    = is_signed & rs[31];
  assign neg_b    = is_signed & rt[31];
  assign mag_a    = neg_a ? (~rs + 32'd1) : rs;
  assign mag_b    = neg_b ? (~rt + 32'd1) : rt;
  // Substitute 1 for a zero divisor so the datapath never produces X; the result is discarded.
  assign divisor  = (rt == 32'd0) ? 32'd1 : mag_b;
  assign quot_mag = mag_a / divisor;
  assign rem_mag  = mag_a % divisor;
  assign quot     = (neg_a ^ neg_b) ? (~quot_mag + 32'd1) : quot_mag;
  assign rem      = neg_a ? (~rem_mag + 32'd1) : rem_mag;

  always_comb begin
    hi       = product[63:32];
    lo       = product[31:0];
    write_en = 1'b1;
    if (is_div) begin
      hi       = rem;
      lo       = quot;
      write_en = (rt != 32'd0);
    end
  end
`else
  always_comb begin
    hi       = product[63:32];
    lo       = product[31:0];
    write_en = 1'b1;
  end
`endif

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: IDLE/RUN FSM, cycle counter, pending result and HI/LO.
// Define MDU_DIV_EN to include DIV/DIVU; otherwise ops 2/3 behave as NOP.
import mdu_pkg::*;

module e_mdu #(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_op_t     op_e;
  mdu_state_t  state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0] pend_hi_reg, pend_hi_next;
  logic [31:0] pend_lo_reg, pend_lo_next;
  logic        pend_we_reg, pend_we_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_we;

  assign op_e = mdu_op_t'(op);

  mdu_calc u_calc (
    .op       (op_e),
    .rs       (rs),
    .rt       (rt),
    .hi       (calc_hi),
    .lo       (calc_lo),
    .write_en (calc_we)
  );

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    pend_we_next = pend_we_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (op_is_multi(op_e)) begin
            state_next   = RUN;
            cnt_next     = ((op_e == OP_MULT) || (op_e == OP_MULTU)) ?
                           CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            pend_hi_next = calc_hi;
            pend_lo_next = calc_lo;
            pend_we_next = calc_we;
          end else if (op_e == OP_MTHI) begin
            hi_next = rs;
          end else if (op_e == OP_MTLO) begin
            lo_next = rs;
          end
        end
      end
      RUN: begin
        // start is ignored here; the hazard unit keeps MD ops out of E while busy.
        if (cnt_reg == CNT_W'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
          if (pend_we_reg) begin
            hi_next = pend_hi_reg;
            lo_next = pend_lo_reg;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
      pend_we_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
      pend_we_reg <= pend_we_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
    end
  end

  assign busy = (state_reg == RUN);
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit in the E stage of the five-stage MIPS pipeline, holding the architectural HI/LO registers. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E-stage decoder. Runs multi-cycle operations with a `busy` signal that the hazard unit uses to stall MFHI/MFLO and further MD instructions in D. HI/LO are read combinationally by the E-stage result mux, which feeds the E/M register and then the M stage.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `start` in 1: the E-stage instruction is an MD op; valid for exactly one cycle per instruction.
- `op` in 3: operation select (mdu_pkg encoding).
- `rs` in 32: operand A, already forwarded.
- `rt` in 32: operand B, already forwarded.
- `busy` out 1: a multi-cycle operation is in flight.
- `HI` out 32: HI register.
- `LO` out 32: LO register.

## Operation
- Op encodings:
  - MULT=0, MULTU=1, DIV=2, DIVU=3 (multi-cycle).
  - MTHI=4, MTLO=5 (single-cycle).
  - 6 and 7 are NOP.
- Multi-cycle ops (`start` with op 0..3 while idle):
  - Latch the result into internal pending registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Assert `busy`.
- Multiply:
  - MULT: signed 32x32 to 64. MULTU: unsigned 32x32 to 64.
  - HI takes the upper 32 bits, LO the lower 32 bits.
- Divide:
  - LO takes the quotient, truncated toward zero. HI takes the remainder, which has the sign of the dividend.
  - DIVU is unsigned.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero: HI/LO are left unchanged, but `busy` still runs the full DIV_CYCLES.
- MTHI/MTLO: write `rs` into HI or LO at the end of the `start` cycle. `busy` is not asserted.
- Two-state FSM:
  - IDLE → RUN on `start` with op 0..3.
  - RUN → IDLE when the counter reaches 1 at a clock edge.
  - HI/LO are committed from the pending registers on that same edge.
- `start` while `busy`=1: ignored, with no state change. The hazard unit guarantees this does not occur; the bench checks that it is ignored.
- `start` with an op not in 0..5: no effect.
- Reset (`reset`=0 at an edge), including mid-RUN:
  - HI=0, LO=0, busy=0, counter=0, FSM=IDLE.
  - Any pending result is discarded.

## Timing
- Reset values: `busy`=0, `HI`=0, `LO`=0.
- Call the cycle in which `start`=1 cycle 0.
- MULT/MULTU:
  - `busy`=1 in cycles 1..MULT_CYCLES.
  - The new HI/LO are visible in cycle MULT_CYCLES+1, the same cycle `busy` falls.
- DIV/DIVU: same pattern, using DIV_CYCLES.
- `busy` is registered; it is not a combinational function of `start`. The hazard unit ORs `start` with `busy` to stall.
- MTHI/MTLO: the new value is visible in cycle 1.
- Back-to-back:
  - A new `start` is accepted in the first cycle `busy`=0 after completion.
  - In that cycle HI/LO already hold the previous result.
- Reads of `HI`/`LO` are combinational from registers. No bypass of pending results.

## Configuration
- `MDU_DIV_EN` defined:
  - The divider is compiled in.
  - DIV/DIVU behave as specified above.
- `MDU_DIV_EN` undefined:
  - No divide logic is present.
  - op 2/3 are treated as NOP: no `busy`, HI/LO unchanged.
  - DIV_CYCLES is unused.

## Structure
- `mdu_pkg` holds:
  - The `mdu_op_t` enum (op encodings).
  - The FSM state typedef `{IDLE, RUN}`.
  - Default cycle-count constants.
- One sub-module, `mdu_calc`: combinational.
  - Computes the 64-bit {hi,lo} result for op 0..3.
  - Divide path is guarded by `MDU_DIV_EN`.
- `e_mdu` holds the FSM, counter, pending registers and HI/LO.

## Test plan
- MULT, rs=0xFFFFFFFE (-2), rt=3:
  - `busy` high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- DIV, rs=-7, rt=2:
  - `busy` high for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/0: busy for 10 cycles, HI/LO unchanged.
- MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 on consecutive cycles:
  - HI updates in cycle 1.
  - LO updates in cycle 2.
  - `busy` stays 0.
- MULT started, `start`+MULT pulsed again in busy cycle 2, `reset`=0 in busy cycle 3:
  - The second start is ignored.
  - After reset: busy=0, HI=LO=0, and no late commit occurs.
- Build without `MDU_DIV_EN`:
  - DIV 10/3 gives busy=0 and HI/LO unchanged.
  - MULT 10*3 still gives LO=30, HI=0 after 5 cycles.
